// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_PC_W    = 16;
    localparam int unsigned FETCH_INSTR_W = 16;

    localparam logic [15:0] RESET_PC = 16'h0000;

    // Instruction field positions consumed by the control decoder
    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned FUNC_MSB = 3;
    localparam int unsigned FUNC_LSB = 0;

    // Byte distance between consecutive 16-bit instructions
    localparam int unsigned PC_INC = 2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_skid_buf.sv
// One-entry holding register for an instruction that arrives while IF/ID is stalled.
module if_skid_buf #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               valid,
    output logic               ready_c,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    assign ready_c = !valid;

    // Clear wins, then a new push (possibly replacing an entry popped this cycle), then pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack memory port, IF/ID register, stall/flush/halt handling.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = FETCH_PC_W,
    parameter int unsigned     INSTR_W  = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(fetch_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [3:0]         if_opcode,
    output logic [3:0]         if_func,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_pc_plus2,
    output logic               halted
);

    fetch_state_e state, state_n;

    logic [PC_W-1:0]    pc, pc_n;
    logic               req_n;
    logic [PC_W-1:0]    addr_n;
    logic               if_valid_n;
    logic [INSTR_W-1:0] if_instr_n;
    logic [PC_W-1:0]    if_pc_n;
    logic [PC_W-1:0]    if_pc_plus2_n;
    logic               halt_pend, halt_pend_n;
    logic               halted_n;

    logic               accept;
    logic               pending;
    logic               hold_ifid;
    logic               skid_empty_n;

    logic               skid_push, skid_pop, skid_clear;
    logic               skid_valid, skid_ready;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    if_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (skid_push),
        .pop      (skid_pop),
        .clear    (skid_clear),
        .in_instr (imem_rdata),
        .in_pc    (imem_addr),
        .valid    (skid_valid),
        .ready_c  (skid_ready),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // Decoder-facing fields are straight slices of the registered instruction
    assign if_opcode = if_instr[OPC_MSB:OPC_LSB];
    assign if_func   = if_instr[FUNC_MSB:FUNC_LSB];

    // Next-state, request and IF/ID update logic
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        req_n         = imem_req;
        addr_n        = imem_addr;
        if_valid_n    = if_valid;
        if_instr_n    = if_instr;
        if_pc_n       = if_pc;
        if_pc_plus2_n = if_pc_plus2;
        halt_pend_n   = halt_pend;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_clear    = 1'b0;
        skid_empty_n  = skid_ready;

        accept    = imem_req && imem_ack;
        pending   = imem_req && !imem_ack;
        hold_ifid = stall && if_valid;

        unique case (state)
            S_RUN: begin
                if (flush) begin
                    // Kill IF/ID and skid; an unacked request must be drained first
                    if_valid_n = 1'b0;
                    skid_clear = 1'b1;
                    pc_n       = redirect_pc;
                    if (pending) begin
                        state_n = S_DRAIN;
                    end else begin
                        req_n  = 1'b1;
                        addr_n = redirect_pc;
                    end
                end else if (halt && if_valid && !stall) begin
                    // Halt instruction leaves IF/ID; anything fetched behind it is dropped
                    if_valid_n = 1'b0;
                    skid_clear = 1'b1;
                    if (pending) begin
                        state_n     = S_DRAIN;
                        halt_pend_n = 1'b1;
                    end else begin
                        state_n = S_HALT;
                        req_n   = 1'b0;
                    end
                end else begin
                    if (!hold_ifid) begin
                        if (skid_valid) begin
                            // Skid content goes first; a coincident ack refills the skid
                            if_valid_n    = 1'b1;
                            if_instr_n    = skid_instr;
                            if_pc_n       = skid_pc;
                            if_pc_plus2_n = skid_pc + PC_W'(PC_INC);
                            skid_pop      = 1'b1;
                            skid_push     = accept;
                        end else if (accept) begin
                            if_valid_n    = 1'b1;
                            if_instr_n    = imem_rdata;
                            if_pc_n       = imem_addr;
                            if_pc_plus2_n = imem_addr + PC_W'(PC_INC);
                        end else begin
                            if_valid_n = 1'b0;
                        end
                    end else if (accept) begin
                        skid_push = 1'b1;
                    end
                    skid_empty_n = !skid_push && (skid_ready || skid_pop);
                    if (accept) begin
                        pc_n = pc + PC_W'(PC_INC);
                    end
                    if (!pending) begin
                        if (skid_empty_n && !hold_ifid) begin
                            req_n  = 1'b1;
                            addr_n = pc_n;
                        end else begin
                            req_n = 1'b0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Waiting out a killed request; its data is never used
                if_valid_n = 1'b0;
                if (flush) begin
                    pc_n = redirect_pc;
                end
                if (accept) begin
                    if (halt_pend) begin
                        state_n     = S_HALT;
                        req_n       = 1'b0;
                        halt_pend_n = 1'b0;
                    end else begin
                        state_n = S_RUN;
                        req_n   = 1'b1;
                        addr_n  = pc_n;
                    end
                end
            end
            S_HALT: begin
                req_n      = 1'b0;
                if_valid_n = 1'b0;
            end
            default: begin
                state_n    = S_HALT;
                req_n      = 1'b0;
                if_valid_n = 1'b0;
            end
        endcase

        halted_n = (state_n == S_HALT);
    end

    // State, PC, request port and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus2 <= PC_W'(PC_INC);
            halt_pend   <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            if_valid    <= if_valid_n;
            if_instr    <= if_instr_n;
            if_pc       <= if_pc_n;
            if_pc_plus2 <= if_pc_plus2_n;
            halt_pend   <= halt_pend_n;
            halted      <= halted_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, scoreboard, vector table, corner sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [3:0]  if_opcode;
    logic [3:0]  if_func;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_func     (if_func),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .halted      (halted)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Instruction memory contents
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'h8005;
            16'h0004: return 16'h9001;
            default:  return a ^ 16'h5A3C;
        endcase
    endfunction

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t exp_q[$];
    bit   drop_next = 1'b0;
    bit   halting   = 1'b0;
    int   mem_lat   = 0;
    int   mem_cnt   = 0;
    logic [15:0] held_addr = '0;
    bit   adv_prev  = 1'b1;

    // Memory responder: ack after mem_lat extra cycles, address must hold while waiting
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (mem_cnt > 0) check("addr_stable", imem_addr, held_addr);
                held_addr = imem_addr;
                if (mem_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    mem_cnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                    mem_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end
        end
    end

    // Scoreboard producer: accepted fetches that must reach IF/ID, in order
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            if (imem_req && imem_ack) begin
                if (drop_next || halting || flush || (halt && if_valid && !stall))
                    drop_next = 1'b0;
                else
                    exp_q.push_back('{pc: imem_addr, instr: imem_rdata});
            end
            if (!halting && flush) begin
                exp_q.delete();
                if (imem_req && !imem_ack) drop_next = 1'b1;
            end else if (!halting && halt && if_valid && !stall) begin
                halting = 1'b1;
                exp_q.delete();
            end
        end
    end

    // Scoreboard consumer: each newly loaded IF/ID entry must match the next expected one
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && if_valid && adv_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_instr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(if_pc), 32'(e.pc));
                check("sb_instr", 32'(if_instr), 32'(e.instr));
            end
        end
        adv_prev = !if_valid || !stall;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        exp_q.delete();
        drop_next = 1'b0;
        halting   = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        logic [3:0]  opc;
        logic [3:0]  func;
        logic [15:0] plus2;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int  cnt;
        bit  found;

        vecs[0] = '{addr: 16'h0000, word: 16'h1234, opc: 4'h1, func: 4'h4, plus2: 16'h0002};
        vecs[1] = '{addr: 16'h0002, word: 16'h8005, opc: 4'h8, func: 4'h5, plus2: 16'h0004};
        vecs[2] = '{addr: 16'h0004, word: 16'h9001, opc: 4'h9, func: 4'h1, plus2: 16'h0006};

        stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = '0;
        assert_reset();
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_if_pc", 32'(if_pc), 32'd0);
        check("rst_if_instr", 32'(if_instr), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Zero-wait streaming: one address per cycle, IF/ID one cycle behind
        for (int i = 0; i < 4; i++) begin
            sample();
            if (i < 3) begin
                check("vec_req", 32'(imem_req), 32'd1);
                check("vec_addr", 32'(imem_addr), 32'(vecs[i].addr));
            end
            if (i >= 1) begin
                check("vec_valid", 32'(if_valid), 32'd1);
                check("vec_instr", 32'(if_instr), 32'(vecs[i-1].word));
                check("vec_opcode", 32'(if_opcode), 32'(vecs[i-1].opc));
                check("vec_func", 32'(if_func), 32'(vecs[i-1].func));
                check("vec_pc", 32'(if_pc), 32'(vecs[i-1].addr));
                check("vec_pc_plus2", 32'(if_pc_plus2), 32'(vecs[i-1].plus2));
            end
        end

        // Stall for three cycles; the in-flight fetch of 0x0008 lands in the skid
        tick(); stall = 1'b1;
        sample();
        check("stall1_ack", 32'(imem_req && imem_ack), 32'd1);
        check("stall1_pc", 32'(if_pc), 32'h0006);
        for (int i = 0; i < 2; i++) begin
            sample();
            check("stall_no_req", 32'(imem_req), 32'd0);
            check("stall_frozen", 32'(if_pc), 32'h0006);
        end
        tick(); stall = 1'b0;
        sample();
        check("unstall_pc", 32'(if_pc), 32'h0006);
        check("unstall_no_req", 32'(imem_req), 32'd0);
        sample();
        check("skid_out_pc", 32'(if_pc), 32'h0008);
        check("skid_out_valid", 32'(if_valid), 32'd1);
        check("skid_next_addr", 32'(imem_addr), 32'h000A);

        // Two-cycle memory, flush while the fetch of 0x0006 is outstanding
        @(negedge clk); #1;
        mem_lat = 1;
        assert_reset();
        sample();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            sample();
            if (imem_req && imem_addr == 16'h0006 && !imem_ack) found = 1'b1;
        end
        check("wait_addr6", 32'(found), 32'd1);
        flush = 1'b1; redirect_pc = 16'h0040;
        tick(); flush = 1'b0;
        sample();
        check("drain_valid", 32'(if_valid), 32'd0);
        check("drain_addr_held", 32'(imem_addr), 32'h0006);
        sample();
        check("redir_addr", 32'(imem_addr), 32'h0040);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_valid0", 32'(if_valid), 32'd0);
        sample();
        check("redir_valid1", 32'(if_valid), 32'd0);
        sample();
        check("redir_valid2", 32'(if_valid), 32'd1);
        check("redir_if_pc", 32'(if_pc), 32'h0040);

        // Ack and flush in the same cycle
        tick(); mem_lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (imem_req && imem_ack) found = 1'b1;
        end
        check("wait_ack", 32'(found), 32'd1);
        flush = 1'b1; redirect_pc = 16'h0100;
        tick(); flush = 1'b0;
        sample();
        check("ackflush_addr", 32'(imem_addr), 32'h0100);
        check("ackflush_req", 32'(imem_req), 32'd1);
        check("ackflush_valid", 32'(if_valid), 32'd0);
        sample();
        check("ackflush_if_pc", 32'(if_pc), 32'h0100);
        check("ackflush_plus2", 32'(if_pc_plus2), 32'h0102);
        check("ackflush_opcode", 32'(if_opcode), 32'h5);
        check("ackflush_func", 32'(if_func), 32'hC);

        // Halt with a fetch still outstanding
        tick(); mem_lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (if_valid && imem_req && !imem_ack) found = 1'b1;
        end
        check("wait_halt_point", 32'(found), 32'd1);
        halt = 1'b1;
        tick(); halt = 1'b0;
        sample();
        check("halt_draining", 32'(halted), 32'd0);
        check("halt_drain_req", 32'(imem_req), 32'd1);
        check("halt_valid", 32'(if_valid), 32'd0);
        sample();
        check("halted", 32'(halted), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (imem_req) cnt++;
        end
        check("halt_req_quiet", 32'(cnt), 32'd0);
        tick(); flush = 1'b1; redirect_pc = 16'h0200;
        tick(); flush = 1'b0;
        sample(); sample();
        check("halt_flush_ignored", 32'(halted), 32'd1);
        check("halt_flush_no_req", 32'(imem_req), 32'd0);
        check("halt_flush_valid", 32'(if_valid), 32'd0);

        // Async reset mid-request at 0x0010, then restart and PC wrap
        @(negedge clk); #1;
        mem_lat = 3;
        assert_reset();
        sample();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            sample();
            if (imem_req && imem_addr == 16'h0010) found = 1'b1;
        end
        check("wait_addr10", 32'(found), 32'd1);
        assert_reset();
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_if_pc", 32'(if_pc), 32'd0);
        mem_lat = 0;
        sample();
        rst_n = 1'b1;
        sample();
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", 32'(imem_addr), 32'h0000);
        tick(); flush = 1'b1; redirect_pc = 16'hFFFE;
        tick(); flush = 1'b0;
        sample();
        check("wrap_addr_top", 32'(imem_addr), 32'hFFFE);
        sample();
        check("wrap_addr_zero", 32'(imem_addr), 32'h0000);
        check("wrap_if_pc", 32'(if_pc), 32'hFFFE);
        check("wrap_plus2", 32'(if_pc_plus2), 32'h0000);
        sample(); sample();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
